// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter.
// Contents:
//   arb_state_e   - FSM state encoding (IDLE / BUSY / RESP)
//   MIN_PORTS / MAX_PORTS - supported requester count range
//   width_min1()  - $clog2 clamped to at least one bit
//   slice_lsb()   - LSB position of a port's slice in a flattened bus
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam int MIN_PORTS = 2;
    localparam int MAX_PORTS = 8;

    // Counter/index width that never collapses to zero bits.
    function automatic int width_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Bit offset of port 'port' inside a bus of 'width'-bit slices.
    function automatic int slice_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational rotate-priority picker.
// Scans the request vector starting just after rr_ptr and wrapping modulo
// NUM_PORTS; the first set bit wins.
// Ports:
//   req        in   NUM_PORTS  request vector
//   rr_ptr     in   PW         index of the most recently served port
//   gnt_onehot out  NUM_PORTS  one-hot winner (all zero when no request)
//   gnt_idx    out  PW         binary index of the winner
//   any        out  1          at least one request is present
module sram_rr_pick
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PW        = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        rr_ptr,
    output logic [NUM_PORTS-1:0] gnt_onehot,
    output logic [PW-1:0]        gnt_idx,
    output logic                 any
);

    logic [PW-1:0] cand_s;
    logic          hit_s;

    // Walk candidates in priority order; only the first set request is taken.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        cand_s     = '0;
        hit_s      = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand_s             = PW'((int'(rr_ptr) + i) % NUM_PORTS);
            hit_s              = req[cand_s] & ~any;
            gnt_onehot[cand_s] = gnt_onehot[cand_s] | hit_s;
            gnt_idx            = hit_s ? cand_s : gnt_idx;
            any                = any | req[cand_s];
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM access sequencer among NUM_PORTS
// requesters. The winner's command is latched and presented downstream until
// the sequencer acknowledges; a watchdog aborts accesses that never complete.
// Ports:
//   sram_clk, rst_n      clock, async active-low reset
//   req_i/wr_en_i        per-port request level and write enable
//   addr_i/wdata_i       per-port command, port p at [p*W +: W]
//   gnt_o/done_o/err_o   owner one-hot, completion pulse, timeout flag
//   rdata_o              read data, valid with done_o
//   busy_o               high in BUSY and RESP
//   mem_req_o/mem_*_o    latched command to the sequencer
//   mem_ack_i/mem_rdata_i completion and read data from the sequencer
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                            sram_clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS-1:0]            wr_en_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]            gnt_o,
    output logic [NUM_PORTS-1:0]            done_o,
    output logic                            err_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            busy_o,
    output logic                            mem_req_o,
    output logic                            mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0]           mem_wdata_o,
    input  logic                            mem_ack_i,
    input  logic [DATA_WIDTH-1:0]           mem_rdata_i
);

    localparam int PW = width_min1(NUM_PORTS);
    localparam int TW = width_min1(TIMEOUT + 1);
    localparam bit WD_ON = (TIMEOUT > 0);
    // Timer value at which the final no-ack BUSY cycle ends the access.
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [TW-1:0] T_SAT  = {TW{1'b1}};

    arb_state_e              state_r;
    logic [PW-1:0]           rr_ptr_r;
    logic [PW-1:0]           win_idx_r;
    logic [TW-1:0]           timer_r;

    logic [NUM_PORTS-1:0]    pick_gnt_s;
    logic [PW-1:0]           pick_idx_s;
    logic                    pick_any_s;

    sram_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_pick (
        .req        (req_i),
        .rr_ptr     (rr_ptr_r),
        .gnt_onehot (pick_gnt_s),
        .gnt_idx    (pick_idx_s),
        .any        (pick_any_s)
    );

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge sram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= PW'(NUM_PORTS - 1);
            win_idx_r   <= '0;
            timer_r     <= '0;
            gnt_o       <= '0;
            done_o      <= '0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            busy_o      <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_wr_en_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        win_idx_r   <= pick_idx_s;
                        gnt_o       <= pick_gnt_s;
                        mem_wr_en_o <= wr_en_i[pick_idx_s];
                        mem_addr_o  <= addr_i[slice_lsb(int'(pick_idx_s), ADDR_WIDTH) +: ADDR_WIDTH];
                        mem_wdata_o <= wdata_i[slice_lsb(int'(pick_idx_s), DATA_WIDTH) +: DATA_WIDTH];
                        mem_req_o   <= 1'b1;
                        busy_o      <= 1'b1;
                        timer_r     <= '0;
                        state_r     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // An ack arriving on the watchdog's last cycle still counts as success.
                    if (mem_ack_i) begin
                        if (!mem_wr_en_o) begin
                            rdata_o <= mem_rdata_i;
                        end
                        mem_req_o <= 1'b0;
                        done_o    <= gnt_o;
                        err_o     <= 1'b0;
                        state_r   <= ST_RESP;
                    end else if (WD_ON && (timer_r == T_LAST)) begin
                        mem_req_o <= 1'b0;
                        done_o    <= gnt_o;
                        err_o     <= 1'b1;
                        state_r   <= ST_RESP;
                    end else begin
                        timer_r <= (timer_r == T_SAT) ? timer_r : timer_r + TW'(1);
                    end
                end
                ST_RESP: begin
                    gnt_o    <= '0;
                    done_o   <= '0;
                    err_o    <= 1'b0;
                    busy_o   <= 1'b0;
                    timer_r  <= '0;
                    rr_ptr_r <= win_idx_r;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    timer_r     <= '0;
                    gnt_o       <= '0;
                    done_o      <= '0;
                    err_o       <= 1'b0;
                    rdata_o     <= '0;
                    busy_o      <= 1'b0;
                    mem_req_o   <= 1'b0;
                    mem_wr_en_o <= 1'b0;
                    mem_addr_o  <= '0;
                    mem_wdata_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter: hand-computed expectations for
// single accesses, round-robin order, read data capture, watchdog abort,
// async reset mid-access and stray acks.
module tb_sram_port_arbiter;

    logic        sram_clk;
    logic        rst_n;
    logic [3:0]  req_i;
    logic [3:0]  wr_en_i;
    logic [31:0] addr_i;
    logic [63:0] wdata_i;
    logic [3:0]  gnt_o;
    logic [3:0]  done_o;
    logic        err_o;
    logic [15:0] rdata_o;
    logic        busy_o;
    logic        mem_req_o;
    logic        mem_wr_en_o;
    logic [7:0]  mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [15:0] mem_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    sram_port_arbiter #(
        .NUM_PORTS  (4),
        .ADDR_WIDTH (8),
        .DATA_WIDTH (16),
        .TIMEOUT    (15)
    ) dut (
        .sram_clk    (sram_clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .wr_en_i     (wr_en_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .mem_req_o   (mem_req_o),
        .mem_wr_en_o (mem_wr_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    initial sram_clk = 1'b0;
    always #5 sram_clk = ~sram_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge sram_clk);
    endtask

    task automatic set_cmd(input int p, input logic wr, input logic [7:0] a, input logic [15:0] d);
        wr_en_i[p]          = wr;
        addr_i[p*8 +: 8]    = a;
        wdata_i[p*16 +: 16] = d;
    endtask

    // Wait (bounded) for the arbiter to present a command downstream.
    task automatic wait_req();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_req_o && n < 20);
        check_eq("wait_mem_req", {31'd0, mem_req_o}, 32'd1);
    endtask

    // One-cycle ack; returns at the negedge where done_o is expected high.
    task automatic ack_pulse(input logic [15:0] rd);
        mem_ack_i   = 1'b1;
        mem_rdata_i = rd;
        tick();
        mem_ack_i   = 1'b0;
    endtask

    int exp_order [5] = '{0, 1, 3, 0, 1};

    initial begin
        rst_n       = 1'b0;
        req_i       = 4'd0;
        wr_en_i     = 4'd0;
        addr_i      = 32'd0;
        wdata_i     = 64'd0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 16'd0;
        #12;
        check_eq("rst_gnt", {28'd0, gnt_o}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check_eq("rst_done_err", {27'd0, done_o, err_o}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Test 1: port 2 write, ack two cycles after the command appears.
        set_cmd(2, 1'b1, 8'h3C, 16'hBEEF);
        req_i = 4'b0100;
        wait_req();
        check_eq("t1_gnt", {28'd0, gnt_o}, 32'h4);
        check_eq("t1_addr", {24'd0, mem_addr_o}, 32'h3C);
        check_eq("t1_wr", {31'd0, mem_wr_en_o}, 32'd1);
        check_eq("t1_wdata", {16'd0, mem_wdata_o}, 32'hBEEF);
        check_eq("t1_busy", {31'd0, busy_o}, 32'd1);
        tick();
        ack_pulse(16'h0000);
        check_eq("t1_done", {28'd0, done_o}, 32'h4);
        check_eq("t1_err", {31'd0, err_o}, 32'd0);
        check_eq("t1_req_dropped", {31'd0, mem_req_o}, 32'd0);
        req_i = 4'b0000;
        tick();
        check_eq("t1_done_pulse", {28'd0, done_o}, 32'h0);
        check_eq("t1_gnt_clear", {28'd0, gnt_o}, 32'h0);

        // Reset so arbitration restarts from rr_ptr = 3.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Test 2: ports 0,1,3 request continuously -> 0,1,3,0,1.
        for (int p = 0; p < 4; p++) set_cmd(p, 1'b1, 8'(8'h10 + p), 16'(16'h100 + p));
        req_i = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            wait_req();
            check_eq($sformatf("t2_gnt%0d", k), {28'd0, gnt_o}, 32'd1 << exp_order[k]);
            check_eq($sformatf("t2_addr%0d", k), {24'd0, mem_addr_o}, 32'h10 + exp_order[k]);
            ack_pulse(16'h0000);
            check_eq($sformatf("t2_done%0d", k), {28'd0, done_o}, 32'd1 << exp_order[k]);
        end
        req_i = 4'b0000;

        // Test 3: port 1 read captures data; a following write keeps it.
        set_cmd(1, 1'b0, 8'h55, 16'h0000);
        req_i = 4'b0010;
        wait_req();
        check_eq("t3_gnt", {28'd0, gnt_o}, 32'h2);
        check_eq("t3_wr", {31'd0, mem_wr_en_o}, 32'd0);
        check_eq("t3_addr", {24'd0, mem_addr_o}, 32'h55);
        ack_pulse(16'h1234);
        check_eq("t3_rdata", {16'd0, rdata_o}, 32'h1234);
        check_eq("t3_done", {28'd0, done_o}, 32'h2);
        set_cmd(1, 1'b1, 8'h56, 16'h7777);
        wait_req();
        check_eq("t3_b2b_gnt", {28'd0, gnt_o}, 32'h2);
        check_eq("t3_b2b_wr", {31'd0, mem_wr_en_o}, 32'd1);
        check_eq("t3_b2b_wdata", {16'd0, mem_wdata_o}, 32'h7777);
        ack_pulse(16'hDEAD);
        check_eq("t3_wr_done", {28'd0, done_o}, 32'h2);
        check_eq("t3_rdata_kept", {16'd0, rdata_o}, 32'h1234);
        req_i = 4'b0000;

        // Test 4a: port 3 read with no ack -> abort after 15 BUSY cycles.
        set_cmd(3, 1'b0, 8'h77, 16'h0000);
        req_i = 4'b1000;
        wait_req();
        for (int i = 0; i < 14; i++) tick();
        check_eq("t4_req_at15", {31'd0, mem_req_o}, 32'd1);
        check_eq("t4_no_done_yet", {28'd0, done_o}, 32'h0);
        tick();
        check_eq("t4_req_dropped", {31'd0, mem_req_o}, 32'd0);
        check_eq("t4_done", {28'd0, done_o}, 32'h8);
        check_eq("t4_err", {31'd0, err_o}, 32'd1);
        check_eq("t4_rdata_kept", {16'd0, rdata_o}, 32'h1234);
        req_i = 4'b0000;
        tick();
        check_eq("t4_err_clear", {31'd0, err_o}, 32'd0);

        // Test 4b: ack on the watchdog's final cycle wins.
        req_i = 4'b1000;
        wait_req();
        for (int i = 0; i < 14; i++) tick();
        ack_pulse(16'hA5A5);
        check_eq("t4b_done", {28'd0, done_o}, 32'h8);
        check_eq("t4b_err", {31'd0, err_o}, 32'd0);
        check_eq("t4b_rdata", {16'd0, rdata_o}, 32'hA5A5);
        req_i = 4'b0000;

        // Test 5: serve port 0, start port 1, reset mid-access.
        set_cmd(0, 1'b1, 8'h01, 16'h1111);
        req_i = 4'b0001;
        wait_req();
        ack_pulse(16'h0000);
        req_i = 4'b0010;
        wait_req();
        check_eq("t5_gnt_pre", {28'd0, gnt_o}, 32'h2);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_gnt", {28'd0, gnt_o}, 32'h0);
        check_eq("t5_rst_req_busy", {30'd0, mem_req_o, busy_o}, 32'h0);
        check_eq("t5_rst_addr", {24'd0, mem_addr_o}, 32'h0);
        check_eq("t5_rst_rdata", {16'd0, rdata_o}, 32'h0);
        tick();
        rst_n = 1'b1;
        req_i = 4'b0011;
        wait_req();
        check_eq("t5_port0_first", {28'd0, gnt_o}, 32'h1);
        ack_pulse(16'h0000);
        check_eq("t5_done", {28'd0, done_o}, 32'h1);
        req_i = 4'b0000;

        // Test 6: req dropped during BUSY, then a stray ack in IDLE.
        req_i = 4'b0001;
        wait_req();
        req_i = 4'b0000;
        tick();
        tick();
        check_eq("t6_still_busy", {31'd0, mem_req_o}, 32'd1);
        ack_pulse(16'h0000);
        check_eq("t6_done", {28'd0, done_o}, 32'h1);
        tick();
        tick();
        ack_pulse(16'hFFFF);
        check_eq("t6_stray_done", {28'd0, done_o}, 32'h0);
        check_eq("t6_stray_busy", {31'd0, busy_o}, 32'd0);
        check_eq("t6_stray_rdata", {16'd0, rdata_o}, 32'h0);
        tick();
        check_eq("t6_stray_done2", {28'd0, done_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
